// File: rtl/mercury2_adc_model_if.sv
// Request/result bundle of the mercury2 ADC behavioural model.
interface mercury2_adc_model_if #(
  parameter int DATA_WIDTH = 10
);
  logic                  trigger;
  logic [2:0]            channel;
  logic                  diffn;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] Dout;
  logic                  OutVal;
  logic [7:0]            overrun_cnt;

  modport master (
    output trigger, channel, diffn, mode,
    input  Dout, OutVal, overrun_cnt
  );

  modport slave (
    input  trigger, channel, diffn, mode,
    output Dout, OutVal, overrun_cnt
  );
endinterface

// File: rtl/mercury2_adc_model.sv
// Behavioural ADC stand-in: fixed-latency conversions fed by per-channel
// synthetic generators (ramp, channel constant, toggle, shared LFSR).
//
// state   | meaning
// IDLE    | result valid, waiting for trigger
// LATCH   | request accepted, loading the conversion timer
// CONVERT | timer counting down to the result load
module mercury2_adc_model #(
  parameter int DATA_WIDTH   = 10,
  parameter int NUM_CHANNELS = 8,
  parameter int CONV_DELAY   = 80,
  parameter int INIT_VALUE   = 1,
  parameter int RAMP_STEP    = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  mercury2_adc_model_if.slave  bus,
  output logic                 adc_mosi,
  output logic                 adc_cs,
  output logic                 adc_clk,
  input  logic                 adc_miso
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LATCH   = 2'd1,
    CONVERT = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    outval_q, outval_d;
  logic [DATA_WIDTH-1:0]   res_q, res_d;
  logic [7:0]              ovr_q, ovr_d;
  logic [DATA_WIDTH-1:0]   ramp_q [NUM_CHANNELS];
  logic [DATA_WIDTH-1:0]   ramp_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] toggle_q, toggle_d;
  logic [15:0]             lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0]   gen;
  logic [DATA_WIDTH-1:0]   ch_res;
  logic                    in_range;
  logic                    unused_miso;

  assign unused_miso = adc_miso;

  // Channel number lands in the top three result bits when they exist.
  generate
    if (DATA_WIDTH >= 3) begin : g_ch_wide
      assign ch_res = DATA_WIDTH'(bus.channel) << (DATA_WIDTH - 3);
    end else begin : g_ch_narrow
      assign ch_res = bus.channel[DATA_WIDTH-1:0];
    end
  endgenerate

  assign in_range = (int'(bus.channel) < NUM_CHANNELS);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    outval_d = outval_q;
    res_d    = res_q;
    ovr_d    = ovr_q;
    ramp_d   = ramp_q;
    toggle_d = toggle_q;
    lfsr_d   = lfsr_q;
    gen      = '1;

    case (state_q)
      IDLE: begin
        if (bus.trigger) begin
          outval_d = 1'b0;
          state_d  = LATCH;
          if (in_range) begin
            case (bus.mode)
              2'd0: begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                  if (bus.channel == 3'(i)) begin
                    ramp_d[i] = ramp_q[i] + DATA_WIDTH'(RAMP_STEP);
                    gen       = ramp_d[i];
                  end
                end
              end
              2'd1: gen = ch_res;
              2'd2: begin
                for (int i = 0; i < NUM_CHANNELS; i++) begin
                  if (bus.channel == 3'(i)) begin
                    toggle_d[i] = ~toggle_q[i];
                    gen         = {DATA_WIDTH{toggle_d[i]}};
                  end
                end
              end
              default: begin
                lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                gen    = lfsr_d[DATA_WIDTH-1:0];
              end
            endcase
          end
          if (bus.diffn) gen[DATA_WIDTH-1] = ~gen[DATA_WIDTH-1];
          res_d = gen;
        end
      end
      LATCH: begin
        cnt_d   = 8'(CONV_DELAY);
        state_d = CONVERT;
        if (bus.trigger && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
      end
      CONVERT: begin
        if (bus.trigger && ovr_q != 8'hFF) ovr_d = ovr_q + 8'd1;
        if (cnt_q == 8'd0) begin
          dout_d   = res_q;
          outval_d = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      dout_q   <= '0;
      outval_q <= 1'b1;
      res_q    <= '0;
      ovr_q    <= '0;
      toggle_q <= '0;
      lfsr_q   <= 16'hACE1;
      for (int i = 0; i < NUM_CHANNELS; i++) ramp_q[i] <= DATA_WIDTH'(INIT_VALUE);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      outval_q <= outval_d;
      res_q    <= res_d;
      ovr_q    <= ovr_d;
      toggle_q <= toggle_d;
      lfsr_q   <= lfsr_d;
      ramp_q   <= ramp_d;
    end
  end

  assign bus.Dout        = dout_q;
  assign bus.OutVal      = outval_q;
  assign bus.overrun_cnt = ovr_q;
  assign adc_mosi        = 1'b0;
  assign adc_cs          = 1'b0;
  assign adc_clk         = 1'b0;

endmodule

// File: tb/tb_mercury2_adc_model.sv
// Directed bench: default instance plus a short-delay, four-channel instance.
module tb_mercury2_adc_model;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic miso = 1'b0;
  logic mosi_a, cs_a, clk_a, mosi_b, cs_b, clk_b;
  int n_total = 0;
  int n_bad = 0;

  always #10 clock = ~clock;

  mercury2_adc_model_if #(.DATA_WIDTH(10)) a ();
  mercury2_adc_model_if #(.DATA_WIDTH(10)) b ();

  mercury2_adc_model dut_a (
    .clock(clock), .reset_n(reset_n), .bus(a),
    .adc_mosi(mosi_a), .adc_cs(cs_a), .adc_clk(clk_a), .adc_miso(miso)
  );

  mercury2_adc_model #(
    .NUM_CHANNELS(4), .CONV_DELAY(0), .INIT_VALUE(10'h3FE)
  ) dut_b (
    .clock(clock), .reset_n(reset_n), .bus(b),
    .adc_mosi(mosi_b), .adc_cs(cs_b), .adc_clk(clk_b), .adc_miso(miso)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_a(input logic [2:0] ch, input logic [1:0] md, input logic df, output int lowc);
    @(negedge clock);
    a.trigger = 1'b1; a.channel = ch; a.mode = md; a.diffn = df;
    @(negedge clock);
    a.trigger = 1'b0;
    lowc = 0;
    while (a.OutVal == 1'b0 && lowc < 500) begin
      lowc++;
      @(negedge clock);
    end
  endtask

  task automatic run_b(input logic [2:0] ch, input logic [1:0] md, input logic df, output int lowc);
    @(negedge clock);
    b.trigger = 1'b1; b.channel = ch; b.mode = md; b.diffn = df;
    @(negedge clock);
    b.trigger = 1'b0;
    lowc = 0;
    while (b.OutVal == 1'b0 && lowc < 50) begin
      lowc++;
      @(negedge clock);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lc;
    a.trigger = 0; a.channel = 0; a.mode = 0; a.diffn = 0;
    b.trigger = 0; b.channel = 0; b.mode = 0; b.diffn = 0;
    repeat (3) @(negedge clock);
    check_val("rst_dout", 32'(a.Dout), 32'h0);
    check_val("rst_outval", 32'(a.OutVal), 32'h1);
    check_val("rst_ovr", 32'(a.overrun_cnt), 32'h0);
    check_val("adc_pins", {29'd0, mosi_a, cs_a, clk_a}, 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    run_a(3'd2, 2'd0, 1'b0, lc);
    check_val("ramp_low_cycles", 32'(lc), 32'd82);
    check_val("ramp_ch2_first", 32'(a.Dout), 32'h2);
    run_a(3'd2, 2'd0, 1'b0, lc);
    check_val("ramp_ch2_second", 32'(a.Dout), 32'h3);

    run_a(3'd5, 2'd2, 1'b0, lc);
    check_val("toggle_ch5_on", 32'(a.Dout), 32'h3FF);
    run_a(3'd5, 2'd2, 1'b0, lc);
    check_val("toggle_ch5_off", 32'(a.Dout), 32'h000);
    run_a(3'd5, 2'd1, 1'b0, lc);
    check_val("const_ch5", 32'(a.Dout), 32'h280);
    run_a(3'd5, 2'd1, 1'b1, lc);
    check_val("const_ch5_diff", 32'(a.Dout), 32'h080);
    run_a(3'd2, 2'd0, 1'b1, lc);
    check_val("ramp_ch2_diff", 32'(a.Dout), 32'h204);
    run_a(3'd0, 2'd3, 1'b0, lc);
    check_val("lfsr_first", 32'(a.Dout), 32'h1C3);
    run_a(3'd0, 2'd3, 1'b1, lc);
    check_val("lfsr_second_diff", 32'(a.Dout), 32'h187);

    // five rejected pulses inside one conversion
    @(negedge clock);
    a.trigger = 1'b1; a.channel = 3'd3; a.mode = 2'd0; a.diffn = 1'b0;
    @(negedge clock);
    a.trigger = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock); a.trigger = 1'b1;
      @(negedge clock); a.trigger = 1'b0;
    end
    check_val("dout_hold_busy", 32'(a.Dout), 32'h187);
    check_val("outval_busy", 32'(a.OutVal), 32'h0);
    lc = 0;
    while (a.OutVal == 1'b0 && lc < 200) begin lc++; @(negedge clock); end
    check_val("ovr_five", 32'(a.overrun_cnt), 32'd5);
    check_val("ovr_single_result", 32'(a.Dout), 32'h2);

    @(negedge clock);
    a.trigger = 1'b1; a.channel = 3'd4;
    repeat (400) @(negedge clock);
    a.trigger = 1'b0;
    lc = 0;
    while (a.OutVal == 1'b0 && lc < 200) begin lc++; @(negedge clock); end
    check_val("ovr_saturate", 32'(a.overrun_cnt), 32'd255);

    // reset in the middle of a conversion
    @(negedge clock);
    a.trigger = 1'b1; a.channel = 3'd1; a.mode = 2'd2;
    @(negedge clock);
    a.trigger = 1'b0;
    repeat (20) @(negedge clock);
    reset_n = 1'b0;
    #1;
    check_val("midrst_outval", 32'(a.OutVal), 32'h1);
    check_val("midrst_dout", 32'(a.Dout), 32'h0);
    check_val("midrst_ovr", 32'(a.overrun_cnt), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    run_a(3'd0, 2'd0, 1'b0, lc);
    check_val("post_rst_ramp", 32'(a.Dout), 32'h2);

    run_b(3'd0, 2'd0, 1'b0, lc);
    check_val("b_low_cycles", 32'(lc), 32'd2);
    check_val("b_ramp_ch0_max", 32'(b.Dout), 32'h3FF);
    run_b(3'd0, 2'd0, 1'b0, lc);
    check_val("b_ramp_ch0_wrap", 32'(b.Dout), 32'h000);
    run_b(3'd1, 2'd0, 1'b0, lc);
    check_val("b_ramp_ch1_kept", 32'(b.Dout), 32'h3FF);

    // trigger held across three out-of-range conversions
    @(negedge clock);
    b.trigger = 1'b1; b.channel = 3'd7; b.mode = 2'd0; b.diffn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      lc = 0;
      while (b.OutVal == 1'b0 && lc < 50) begin lc++; @(negedge clock); end
      check_val($sformatf("b_held_low_%0d", k), 32'(lc), 32'd2);
      check_val($sformatf("b_held_dout_%0d", k), 32'(b.Dout), 32'h3FF);
    end
    b.trigger = 1'b0;
    run_b(3'd7, 2'd1, 1'b0, lc);
    check_val("b_oor_const", 32'(b.Dout), 32'h3FF);
    run_b(3'd2, 2'd1, 1'b0, lc);
    check_val("b_const_ch2", 32'(b.Dout), 32'h100);
    run_b(3'd2, 2'd0, 1'b0, lc);
    check_val("b_ramp_ch2", 32'(b.Dout), 32'h3FF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/mercury2_adc_model.md
MERCURY2_ADC_MODEL -- requirements
Module: mercury2_adc_model

Interface
REQ-001 Parameter DATA_WIDTH, default 10, conversion result width; legal range 1..16.
REQ-002 Parameter NUM_CHANNELS, default 8, number of modelled input channels; legal range 1..8.
REQ-003 Parameter CONV_DELAY, default 80, CONVERT-state cycle count (80 cycles is 1.6 us at 50 MHz); legal range 0..255.
REQ-004 Parameter INIT_VALUE, default 1, ramp generator reset value per channel.
REQ-005 Parameter RAMP_STEP, default 1, ramp increment per accepted conversion.
REQ-006 clock  input  1  50 MHz system clock; all logic on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 trigger  input  1  conversion request, sampled only in IDLE.
REQ-009 channel  input  3  channel select.
REQ-010 diffn  input  1  1 = differential (offset-binary result), 0 = single-ended.
REQ-011 mode  input  2  generator: 0 ramp, 1 channel constant, 2 alternating, 3 LFSR.
REQ-012 Dout  output  DATA_WIDTH  registered conversion result.
REQ-013 OutVal  output  1  registered; 1 = Dout valid and model idle.
REQ-014 overrun_cnt  output  8  saturating count of triggers rejected while busy.
REQ-015 adc_mosi, adc_cs, adc_clk  output  1 each  tied to 0; adc_miso  input  1  ignored.

Function
REQ-016 FSM states: IDLE, LATCH, CONVERT; any other encoding -> IDLE on next edge.
REQ-017 IDLE with trigger=1 at edge k: latch channel, diffn, mode; update generator; OutVal <= 0; -> LATCH.
REQ-018 LATCH: counter (8-bit) <= CONV_DELAY; -> CONVERT.
REQ-019 CONVERT: counter == 0 -> Dout <= computed result, OutVal <= 1, -> IDLE; else counter decrements.
REQ-020 OutVal is low for exactly CONV_DELAY+2 cycles per conversion; Dout and OutVal change on the same edge.
REQ-021 Dout holds its previous value throughout LATCH and CONVERT.
REQ-022 trigger=1 in LATCH or CONVERT: request dropped, overrun_cnt increments, saturating at 255.
REQ-023 Trigger held high: a new conversion starts on the first edge in IDLE (one OutVal-high cycle between conversions).
REQ-024 Mode 0: ramp[ch] <= ramp[ch] + RAMP_STEP, modulo 2^DATA_WIDTH (wraps max->0); result = new ramp[ch].
REQ-025 Mode 1: result = ch placed in the 3 MSBs of the result, zeros below; for DATA_WIDTH<3, the DATA_WIDTH LSBs of ch; no generator state changes.
REQ-026 Mode 2: toggle[ch] inverts; result = all ones if new toggle=1, else 0.
REQ-027 Mode 3: one shared 16-bit Fibonacci LFSR, taps 16,14,13,11, advances once per accepted mode-3 conversion; result = low DATA_WIDTH bits of the new state.
REQ-028 Generators for channels and modes not selected hold their state.
REQ-029 diffn=1: result MSB inverted before loading Dout; generator state unaffected.
REQ-030 channel >= NUM_CHANNELS: no generator update; result = all ones; normal timing.

Reset
REQ-031 reset_n=0 forces at once, at any time including mid-conversion: state IDLE, counter 0, Dout 0, OutVal 1, overrun_cnt 0, ramp[all] INIT_VALUE, toggle[all] 0, LFSR 16'hACE1.
REQ-032 First rising edge after reset_n deasserts samples trigger normally.

Verification
REQ-033 Defaults, reset, trigger one cycle on ch 2, mode 0, diffn 0 -> OutVal low 82 cycles, then Dout=2, OutVal=1; second trigger -> Dout=3.
REQ-034 Ramp at 10'h3FF on ch 0, trigger mode 0 -> Dout=10'h000 (wrap); ch 1 ramp unchanged.
REQ-035 Trigger pulsed 5 times during one conversion -> overrun_cnt=5, Dout gets single result; 300 rejected triggers -> overrun_cnt=255.
REQ-036 Mode 2 ch 5 twice -> Dout 10'h3FF then 10'h000; mode 1 ch 5 -> 10'h280; mode 1 ch 5, diffn 1 -> 10'h080.
REQ-037 reset_n low during CONVERT -> OutVal=1, Dout=0 immediately; next ch 0 mode 0 conversion -> Dout=2.
REQ-038 CONV_DELAY=0, trigger held high 3 conversions, channel=7, NUM_CHANNELS=4 -> OutVal low 2 cycles each, Dout=10'h3FF.
